video_timing_rx: RTL and testbench
==================================

// Module: video_timing_rx
// PURPOSE
//  Sink-side companion to the picosoc video timing generator. Samples incoming hsync/vsync/data_en,
//  recovers active-area pixel position, measures line/frame geometry and declares lock once
//  the geometry is stable. Used to validate generator output and to drive capture/overlay logic.
// PARAMETERS
//  LOCK_FRAMES  2        consecutive matching frames required to assert locked (1..15)
//  TIMEOUT      65535    clocks without hsync rise before returning to SEARCH
//  SYNC_POL     1        1 = active-high sync inputs, 0 = active-low (inverted at input stage)
// PORTS
//  clk          in   1   pixel clock; single clock domain
//  resetn       in   1   synchronous, active-low reset
//  hsync        in   1   horizontal sync (polarity per SYNC_POL)
//  vsync        in   1   vertical sync (polarity per SYNC_POL)
//  data_en      in   1   active-pixel qualifier, active-high
//  de_out       out  1   data_en delayed to align with xpos/ypos
//  xpos         out  16  pixel index in active line, valid when de_out
//  ypos         out  16  active line index in frame, valid when de_out
//  h_total      out  16  measured clocks per line (last completed frame)
//  h_active     out  16  measured data_en-high clocks per line
//  v_total      out  16  measured lines per frame
//  v_active     out  16  measured lines containing >=1 data_en cycle
//  frame_start  out  1   one-cycle pulse on detected vsync rise
//  locked       out  1   geometry stable for LOCK_FRAMES frames
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): all outputs 0, counters 0, state SEARCH.
//  - Input stage: hs/vs/de registered (s_*), then previous copy (p_*); edges = s & ~p.
//    Latency input->de_out/xpos/ypos/frame_start = 2 clocks.
//  - Horizontal: h_cnt increments each clock, saturates at 16'hFFFF; on hs rise, line_len <= h_cnt+1,
//    h_cnt <= 0. de_cnt counts de-high clocks per line, latched to line_act on de fall.
//  - xpos: 0 on first de cycle of line, +1 per de cycle; holds value while de low.
//  - ypos: reset to 0 at vs rise; increments on each de rise except the first of the frame.
//  - Vertical: line_cnt +1 per hs rise; act_lines +1 on first de rise in a line. Both saturate.
//  - Frame end (vs rise): h_total/h_active <= line_len/line_act of last line; v_total <= line_cnt;
//    v_active <= act_lines; line_cnt, act_lines cleared. hs rise and vs rise in same cycle: line
//    closes first, then frame; that hs rise counts toward the NEW frame (line_cnt <= 1).
//  - FSM: SEARCH -> MEASURE on first vs rise (no compare, prev_valid=0).
//    MEASURE at vs rise: if prev_valid and all four measurements equal stored -> match_cnt+1, else
//    match_cnt <= 0; store measurements; prev_valid <= 1. match_cnt reaching LOCK_FRAMES -> LOCKED.
//    LOCKED at vs rise: mismatch -> MEASURE, match_cnt 0, locked deasserts same cycle as update.
//    Any state: TIMEOUT clocks without hs rise -> SEARCH, prev_valid 0, locked 0; geometry outputs hold.
//  - locked = (state == LOCKED), registered.
//  - Mid-frame reset: next vs rise is treated as first (SEARCH), partial frame never measured.
// CONFIGURATION
//  VIDEO_TIMING_RX_SYNCW_EN defined: adds outputs h_sync_w[15:0], v_sync_w[15:0] (clocks of hs high
//  per line, lines of vs high per frame, latched on sync fall); both join the lock compare.
//  Not defined: ports absent, compare uses the four geometry values only.
// TESTING
//  1. Drive generator 640x480 timing (fp16/sync64/bp80, v 3/4/16) -> h_total=800, h_active=640,
//     v_total=503, v_active=480; locked=1 two clocks after 4th vs rise edge (LOCK_FRAMES=2).
//  2. Locked stream, first pixel of line 0 -> de_out=1, xpos=0, ypos=0 two clocks later; last
//     pixel of frame -> xpos=639, ypos=479.
//  3. After lock, shorten one line to 799 clocks -> at next vs rise locked=0, state MEASURE;
//     restore timing -> locked=1 again after 2 further matching frames.
//  4. Stop hsync for TIMEOUT+1 clocks -> locked=0, state SEARCH, h_total still 800.
//  5. resetn=0 for 1 clock mid-frame -> all outputs 0; relock needs 4 full vs rises.
//  6. SYNC_POL=0 with inverted syncs -> identical measurements and lock timing to scenario 1;
//     with VIDEO_TIMING_RX_SYNCW_EN: h_sync_w=64, v_sync_w=4.

Source files
------------

// File: rtl/video_timing_rx.sv
// Sink-side video timing receiver: samples hsync/vsync/data_en, recovers the active-area
// pixel position, measures line/frame geometry and declares lock once it is stable.
// Optional feature macro: VIDEO_TIMING_RX_SYNCW_EN adds h_sync_w/v_sync_w outputs (sync pulse
// widths), which then also take part in the lock comparison.
module video_timing_rx #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned TIMEOUT     = 65535,
  parameter bit          SYNC_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        data_en,
  output logic        de_out,
  output logic [15:0] xpos,
  output logic [15:0] ypos,
  output logic [15:0] h_total,
  output logic [15:0] h_active,
  output logic [15:0] v_total,
  output logic [15:0] v_active,
  output logic        frame_start,
  output logic        locked
`ifdef VIDEO_TIMING_RX_SYNCW_EN
  ,
  output logic [15:0] h_sync_w,
  output logic [15:0] v_sync_w
`endif
);

  localparam logic        Inv        = ~SYNC_POL;
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
  localparam logic [3:0]  LockVal    = 4'(LOCK_FRAMES);
`ifdef VIDEO_TIMING_RX_SYNCW_EN
  localparam int unsigned MeasW = 96;
`else
  localparam int unsigned MeasW = 64;
`endif

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Input stage
  logic s_hs, s_vs, s_de, p_hs, p_vs, p_de;
  logic hs_rise, vs_rise, de_rise, de_fall;

  // Line / frame measurement
  logic [15:0] h_cnt_q, line_len_q, line_len_d, de_cnt_q, line_act_q, line_act_d;
  logic [15:0] line_cnt_q, act_lines_q;
  logic        line_has_de_q, first_act;

  // Lock FSM
  state_e           state_q, state_d;
  logic [3:0]       match_cnt_q, match_cnt_d, match_inc;
  logic             prev_valid_q, prev_valid_d;
  logic [MeasW-1:0] meas, stored_q, stored_d;
  logic [15:0]      to_cnt_q;
  logic             timeout, geo_upd;

  // Output registers
  logic        de_out_q, frame_start_q, locked_q, y_first_q;
  logic [15:0] xpos_q, ypos_q, h_total_q, h_active_q, v_total_q, v_active_q;

  // Register the syncs (polarity-normalised) and keep one previous copy for edge detection
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_hs <= 1'b0; s_vs <= 1'b0; s_de <= 1'b0;
      p_hs <= 1'b0; p_vs <= 1'b0; p_de <= 1'b0;
    end else begin
      s_hs <= hsync ^ Inv;
      s_vs <= vsync ^ Inv;
      s_de <= data_en;
      p_hs <= s_hs;
      p_vs <= s_vs;
      p_de <= s_de;
    end
  end

  assign hs_rise = s_hs & ~p_hs;
  assign vs_rise = s_vs & ~p_vs;
  assign de_rise = s_de & ~p_de;
  assign de_fall = ~s_de & p_de;

  // A de rise right on an hs rise belongs to the line that hs rise opens
  assign first_act  = de_rise & (hs_rise | ~line_has_de_q);
  assign line_len_d = hs_rise ? sat_inc(h_cnt_q) : line_len_q;
  assign line_act_d = de_fall ? de_cnt_q : line_act_q;

  // Per-line and per-frame counters; a same-cycle hs rise counts toward the new frame
  always_ff @(posedge clk) begin
    if (!resetn) begin
      h_cnt_q       <= '0;
      line_len_q    <= '0;
      de_cnt_q      <= '0;
      line_act_q    <= '0;
      line_cnt_q    <= '0;
      act_lines_q   <= '0;
      line_has_de_q <= 1'b0;
    end else begin
      h_cnt_q    <= hs_rise ? 16'd0 : sat_inc(h_cnt_q);
      line_len_q <= line_len_d;
      line_act_q <= line_act_d;
      if (hs_rise)    de_cnt_q <= {15'd0, s_de};
      else if (s_de)  de_cnt_q <= sat_inc(de_cnt_q);
      if (hs_rise)      line_has_de_q <= de_rise;
      else if (de_rise) line_has_de_q <= 1'b1;
      if (vs_rise)      line_cnt_q <= {15'd0, hs_rise};
      else if (hs_rise) line_cnt_q <= sat_inc(line_cnt_q);
      if (vs_rise)        act_lines_q <= {15'd0, first_act};
      else if (first_act) act_lines_q <= sat_inc(act_lines_q);
    end
  end

`ifdef VIDEO_TIMING_RX_SYNCW_EN
  logic        hs_fall, vs_fall;
  logic [15:0] hs_hi_cnt_q, vs_ln_cnt_q, h_sync_w_q, v_sync_w_q, h_sync_w_d, v_sync_w_d;

  assign hs_fall    = ~s_hs & p_hs;
  assign vs_fall    = ~s_vs & p_vs;
  assign h_sync_w_d = hs_fall ? hs_hi_cnt_q : h_sync_w_q;
  assign v_sync_w_d = vs_fall ? vs_ln_cnt_q : v_sync_w_q;

  // Sync pulse widths: hs in clocks, vs in hs rises seen while vs is high
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hs_hi_cnt_q <= '0;
      vs_ln_cnt_q <= '0;
      h_sync_w_q  <= '0;
      v_sync_w_q  <= '0;
    end else begin
      if (hs_rise)   hs_hi_cnt_q <= 16'd1;
      else if (s_hs) hs_hi_cnt_q <= sat_inc(hs_hi_cnt_q);
      if (vs_rise)              vs_ln_cnt_q <= {15'd0, hs_rise};
      else if (s_vs && hs_rise) vs_ln_cnt_q <= sat_inc(vs_ln_cnt_q);
      h_sync_w_q <= h_sync_w_d;
      v_sync_w_q <= v_sync_w_d;
    end
  end

  assign h_sync_w = h_sync_w_q;
  assign v_sync_w = v_sync_w_q;
  assign meas = {line_len_d, line_act_d, line_cnt_q, act_lines_q, h_sync_w_d, v_sync_w_d};
`else
  assign meas = {line_len_d, line_act_d, line_cnt_q, act_lines_q};
`endif

  assign timeout   = (to_cnt_q == TimeoutVal);
  assign match_inc = (match_cnt_q == 4'hF) ? 4'hF : match_cnt_q + 4'd1;

  // Lock FSM next state; geometry is only published once a full frame has been seen
  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    prev_valid_d = prev_valid_q;
    stored_d     = stored_q;
    geo_upd      = 1'b0;
    if (timeout) begin
      state_d      = StSearch;
      prev_valid_d = 1'b0;
      match_cnt_d  = '0;
    end else if (vs_rise) begin
      unique case (state_q)
        StSearch: begin
          state_d      = StMeasure;
          prev_valid_d = 1'b0;
          match_cnt_d  = '0;
        end
        StMeasure, StLocked: begin
          geo_upd      = 1'b1;
          stored_d     = meas;
          prev_valid_d = 1'b1;
          if (prev_valid_q && (meas == stored_q)) begin
            match_cnt_d = match_inc;
            if (match_inc >= LockVal) state_d = StLocked;
          end else begin
            match_cnt_d = '0;
            state_d     = StMeasure;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  // Lock FSM state and the hsync-loss watchdog
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StSearch;
      match_cnt_q  <= '0;
      prev_valid_q <= 1'b0;
      stored_q     <= '0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      prev_valid_q <= prev_valid_d;
      stored_q     <= stored_d;
      if (hs_rise)              to_cnt_q <= '0;
      else if (!timeout)        to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  // Registered outputs: position, qualifiers, status and published geometry
  always_ff @(posedge clk) begin
    if (!resetn) begin
      de_out_q      <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      y_first_q     <= 1'b1;
      xpos_q        <= '0;
      ypos_q        <= '0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
    end else begin
      de_out_q      <= s_de;
      frame_start_q <= vs_rise;
      locked_q      <= (state_d == StLocked);
      if (s_de) xpos_q <= de_rise ? 16'd0 : xpos_q + 16'd1;
      if (vs_rise) begin
        ypos_q    <= '0;
        y_first_q <= ~de_rise;
      end else if (de_rise) begin
        if (y_first_q) y_first_q <= 1'b0;
        else           ypos_q    <= ypos_q + 16'd1;
      end
      if (geo_upd) begin
        h_total_q  <= line_len_d;
        h_active_q <= line_act_d;
        v_total_q  <= line_cnt_q;
        v_active_q <= act_lines_q;
      end
    end
  end

  assign de_out      = de_out_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign v_total     = v_total_q;
  assign v_active    = v_active_q;

endmodule

// File: tb/tb_video_timing_rx.sv
// Bench for video_timing_rx: a reduced-size raster generator drives an active-high DUT and an
// active-low DUT (inverted syncs) side by side; each task checks one behaviour.
module tb_video_timing_rx;

  localparam int H_ACT = 16, H_FP = 2, H_SW = 4, H_BP = 3;
  localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
  localparam int V_ACT = 6, V_FP = 1, V_SW = 2, V_BP = 2;
  localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
  localparam int VS_LINE = V_ACT + V_FP;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic hsync = 1'b0, vsync = 1'b0, data_en = 1'b0;
  logic hsync_n, vsync_n;
  assign hsync_n = ~hsync;
  assign vsync_n = ~vsync;

  logic        a_de_out, a_frame_start, a_locked, b_de_out, b_frame_start, b_locked;
  logic [15:0] a_xpos, a_ypos, a_h_total, a_h_active, a_v_total, a_v_active;
  logic [15:0] b_xpos, b_ypos, b_h_total, b_h_active, b_v_total, b_v_active;
`ifdef VIDEO_TIMING_RX_SYNCW_EN
  logic [15:0] a_hsw, a_vsw, b_hsw, b_vsw;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int gv = 0, gh = 0;
  int short_v = -1;

  always #5 clk = ~clk;

  video_timing_rx #(.LOCK_FRAMES(2), .TIMEOUT(TMO), .SYNC_POL(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .hsync(hsync), .vsync(vsync), .data_en(data_en),
    .de_out(a_de_out), .xpos(a_xpos), .ypos(a_ypos), .h_total(a_h_total),
    .h_active(a_h_active), .v_total(a_v_total), .v_active(a_v_active),
    .frame_start(a_frame_start), .locked(a_locked)
`ifdef VIDEO_TIMING_RX_SYNCW_EN
    , .h_sync_w(a_hsw), .v_sync_w(a_vsw)
`endif
  );

  video_timing_rx #(.LOCK_FRAMES(2), .TIMEOUT(TMO), .SYNC_POL(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .hsync(hsync_n), .vsync(vsync_n), .data_en(data_en),
    .de_out(b_de_out), .xpos(b_xpos), .ypos(b_ypos), .h_total(b_h_total),
    .h_active(b_h_active), .v_total(b_v_total), .v_active(b_v_active),
    .frame_start(b_frame_start), .locked(b_locked)
`ifdef VIDEO_TIMING_RX_SYNCW_EN
    , .h_sync_w(b_hsw), .v_sync_w(b_vsw)
`endif
  );

  // Drive the pixel at (gv, gh) on the falling edge and advance the raster position
  task automatic gen_pixel();
    int len;
    @(negedge clk);
    hsync   = (gh >= H_ACT + H_FP) && (gh < H_ACT + H_FP + H_SW);
    vsync   = (gv >= VS_LINE) && (gv < VS_LINE + V_SW);
    data_en = (gv < V_ACT) && (gh < H_ACT);
    len = (gv == short_v) ? H_TOT - 1 : H_TOT;
    gh++;
    if (gh >= len) begin
      gh = 0;
      gv++;
      if (gv == V_TOT) gv = 0;
    end
  endtask

  task automatic gen_until(input int v, input int h);
    int guard = 0;
    while (!(gv == v && gh == h) && guard < 2 * V_TOT * H_TOT) begin
      gen_pixel();
      guard++;
    end
    if (!(gv == v && gh == h)) begin
      n_cmp++; n_bad++;
      $display("FAIL gen_until: position %0d,%0d never reached (at %0d,%0d)", v, h, gv, gh);
    end
  endtask

  // Drive the first pixel of the vsync pulse (the input-side vs rise)
  task automatic vs_edge();
    gen_until(VS_LINE, 0);
    gen_pixel();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      hsync = 1'b0; vsync = 1'b0; data_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_de_out, a_xpos, a_ypos, a_h_total, a_h_active, a_v_total, a_v_active,
         a_frame_start, a_locked} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: outputs got %0h want 0", {a_de_out, a_xpos, a_ypos, a_h_total,
               a_h_active, a_v_total, a_v_active, a_frame_start, a_locked});
    end
    n_cmp++;
    if ({b_de_out, b_xpos, b_ypos, b_h_total, b_locked} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: outputs got %0h want 0", {b_de_out, b_xpos, b_ypos, b_h_total,
               b_locked});
    end
`ifdef VIDEO_TIMING_RX_SYNCW_EN
    n_cmp++;
    if ({a_hsw, a_vsw} !== 32'd0) begin
      n_bad++; $display("FAIL reset_syncw: got %0h want 0", {a_hsw, a_vsw});
    end
`endif
    resetn = 1'b1;
    gv = 0; gh = 0;
  endtask

  task automatic test_lock();
    vs_edge(); gen_pixel(); gen_pixel();
    n_cmp++;
    if (a_h_total !== 16'd0) begin
      n_bad++; $display("FAIL search_no_measure: h_total got %0d want 0", a_h_total);
    end
    vs_edge(); gen_pixel(); gen_pixel();
    n_cmp++;
    if ({a_h_total, a_h_active, a_v_total, a_v_active} !== {16'd25, 16'd16, 16'd11, 16'd6}) begin
      n_bad++;
      $display("FAIL geometry_rise2: got %0d/%0d/%0d/%0d want 25/16/11/6", a_h_total,
               a_h_active, a_v_total, a_v_active);
    end
    vs_edge(); gen_pixel(); gen_pixel();
    n_cmp++;
    if (a_locked !== 1'b0) begin
      n_bad++; $display("FAIL lock_rise3: locked got %0b want 0", a_locked);
    end
    vs_edge(); gen_pixel();
    n_cmp++;
    if ({a_locked, a_frame_start} !== 2'b00) begin
      n_bad++; $display("FAIL lock_rise4_1clk: locked/fs got %b want 00", {a_locked, a_frame_start});
    end
    gen_pixel();
    n_cmp++;
    if ({a_locked, a_frame_start} !== 2'b11) begin
      n_bad++; $display("FAIL lock_rise4_2clk: locked/fs got %b want 11", {a_locked, a_frame_start});
    end
    n_cmp++;
    if ({b_locked, b_frame_start} !== 2'b11) begin
      n_bad++; $display("FAIL pol0_lock: locked/fs got %b want 11", {b_locked, b_frame_start});
    end
    gen_pixel();
    n_cmp++;
    if (a_frame_start !== 1'b0) begin
      n_bad++; $display("FAIL frame_start_pulse: got %0b want 0", a_frame_start);
    end
  endtask

  task automatic test_position();
    gen_until(0, 0); gen_pixel(); gen_pixel(); gen_pixel();
    n_cmp++;
    if ({a_de_out, a_xpos, a_ypos} !== {1'b1, 16'd0, 16'd0}) begin
      n_bad++; $display("FAIL pos_first: de/x/y got %0b/%0d/%0d want 1/0/0", a_de_out, a_xpos, a_ypos);
    end
    gen_until(2, 7); gen_pixel(); gen_pixel(); gen_pixel();
    n_cmp++;
    if ({a_de_out, a_xpos, a_ypos} !== {1'b1, 16'd7, 16'd2}) begin
      n_bad++; $display("FAIL pos_mid: de/x/y got %0b/%0d/%0d want 1/7/2", a_de_out, a_xpos, a_ypos);
    end
    gen_until(V_ACT - 1, H_ACT - 1); gen_pixel(); gen_pixel(); gen_pixel();
    n_cmp++;
    if ({a_de_out, a_xpos, a_ypos} !== {1'b1, 16'd15, 16'd5}) begin
      n_bad++; $display("FAIL pos_last: de/x/y got %0b/%0d/%0d want 1/15/5", a_de_out, a_xpos, a_ypos);
    end
    gen_pixel();
    n_cmp++;
    if ({a_de_out, a_xpos} !== {1'b0, 16'd15}) begin
      n_bad++; $display("FAIL pos_hold: de/x got %0b/%0d want 0/15", a_de_out, a_xpos);
    end
  endtask

  task automatic test_mismatch();
    gen_until(0, 0);
    short_v = VS_LINE - 2;
    gen_until(VS_LINE - 1, 0);
    short_v = -1;
    vs_edge(); gen_pixel();
    n_cmp++;
    if (a_locked !== 1'b1) begin
      n_bad++; $display("FAIL mismatch_1clk: locked got %0b want 1", a_locked);
    end
    gen_pixel();
    n_cmp++;
    if ({a_locked, a_h_total, a_v_total} !== {1'b0, 16'd24, 16'd11}) begin
      n_bad++;
      $display("FAIL mismatch_drop: locked/h_total/v_total got %0b/%0d/%0d want 0/24/11",
               a_locked, a_h_total, a_v_total);
    end
    vs_edge(); gen_pixel(); gen_pixel();
    n_cmp++;
    if ({a_locked, a_h_total} !== {1'b0, 16'd25}) begin
      n_bad++; $display("FAIL restore_1: locked/h_total got %0b/%0d want 0/25", a_locked, a_h_total);
    end
    vs_edge(); gen_pixel(); gen_pixel();
    n_cmp++;
    if (a_locked !== 1'b0) begin
      n_bad++; $display("FAIL restore_2: locked got %0b want 0", a_locked);
    end
    vs_edge(); gen_pixel(); gen_pixel();
    n_cmp++;
    if (a_locked !== 1'b1) begin
      n_bad++; $display("FAIL relock: locked got %0b want 1", a_locked);
    end
  endtask

  task automatic test_timeout();
    gen_until(0, H_ACT + H_FP); gen_pixel();
    idle(TMO - 10);
    n_cmp++;
    if (a_locked !== 1'b1) begin
      n_bad++; $display("FAIL timeout_early: locked got %0b want 1", a_locked);
    end
    idle(20);
    n_cmp++;
    if ({a_locked, b_locked, a_h_total} !== {1'b0, 1'b0, 16'd25}) begin
      n_bad++;
      $display("FAIL timeout: locked a/b h_total got %0b/%0b/%0d want 0/0/25", a_locked,
               b_locked, a_h_total);
    end
    gv = 0; gh = 0;
    vs_edge(); vs_edge(); vs_edge(); gen_pixel(); gen_pixel();
    n_cmp++;
    if (a_locked !== 1'b0) begin
      n_bad++; $display("FAIL timeout_rise3: locked got %0b want 0", a_locked);
    end
    vs_edge(); gen_pixel(); gen_pixel();
    n_cmp++;
    if (a_locked !== 1'b1) begin
      n_bad++; $display("FAIL timeout_relock: locked got %0b want 1", a_locked);
    end
  endtask

  task automatic test_midframe_reset();
    gen_until(3, 8);
    resetn = 1'b0;
    gen_pixel();
    resetn = 1'b1;
    n_cmp++;
    if ({a_de_out, a_xpos, a_ypos, a_h_total, a_h_active, a_v_total, a_v_active,
         a_frame_start, a_locked} !== '0) begin
      n_bad++;
      $display("FAIL midreset: outputs got %0h want 0", {a_de_out, a_xpos, a_ypos, a_h_total,
               a_h_active, a_v_total, a_v_active, a_frame_start, a_locked});
    end
    vs_edge(); gen_pixel(); gen_pixel();
    n_cmp++;
    if ({a_locked, a_h_total} !== {1'b0, 16'd0}) begin
      n_bad++; $display("FAIL midreset_rise1: locked/h_total got %0b/%0d want 0/0", a_locked, a_h_total);
    end
    vs_edge(); gen_pixel(); gen_pixel();
    n_cmp++;
    if ({a_locked, a_h_total, a_v_total} !== {1'b0, 16'd25, 16'd11}) begin
      n_bad++;
      $display("FAIL midreset_rise2: locked/h_total/v_total got %0b/%0d/%0d want 0/25/11",
               a_locked, a_h_total, a_v_total);
    end
    vs_edge(); gen_pixel(); gen_pixel();
    n_cmp++;
    if (a_locked !== 1'b0) begin
      n_bad++; $display("FAIL midreset_rise3: locked got %0b want 0", a_locked);
    end
    vs_edge(); gen_pixel(); gen_pixel();
    n_cmp++;
    if (a_locked !== 1'b1) begin
      n_bad++; $display("FAIL midreset_rise4: locked got %0b want 1", a_locked);
    end
  endtask

  task automatic test_sync_pol();
    n_cmp++;
    if ({b_locked, b_h_total, b_h_active, b_v_total, b_v_active} !==
        {1'b1, 16'd25, 16'd16, 16'd11, 16'd6}) begin
      n_bad++;
      $display("FAIL pol0_geometry: locked/ht/ha/vt/va got %0b/%0d/%0d/%0d/%0d want 1/25/16/11/6",
               b_locked, b_h_total, b_h_active, b_v_total, b_v_active);
    end
`ifdef VIDEO_TIMING_RX_SYNCW_EN
    n_cmp++;
    if ({a_hsw, a_vsw, b_hsw, b_vsw} !== {16'd4, 16'd2, 16'd4, 16'd2}) begin
      n_bad++;
      $display("FAIL sync_width: a %0d/%0d b %0d/%0d want 4/2 4/2", a_hsw, a_vsw, b_hsw, b_vsw);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_lock();
    test_position();
    test_mismatch();
    test_timeout();
    test_midframe_reset();
    test_sync_pol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
